// File: rtl/sumador_segmentado.sv
// Pipelined adder/subtractor: ripple carry split into STAGES registered chunks,
// with optional signed saturation, carry/overflow flags and a global stall.
module sumador_segmentado #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             sat,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf,
  output logic             valid_out
);

  localparam int CW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("sumador_segmentado: WIDTH must be >= 2 and a multiple of STAGES, STAGES in 1..4");
  end

  // Operands travel whole (b already conditionally inverted); s fills in chunk by chunk.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cy;
    logic             sat;
  } stg_t;

  logic [STAGES:1] vld_pipe;
  logic            fin_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (enb) begin
      for (int k = STAGES; k >= 2; k--) vld_pipe[k] <= vld_pipe[k-1];
      vld_pipe[1] <= valid_in;
    end
  end

  assign valid_out = vld_pipe[STAGES];

  if (STAGES == 1) begin : g_fv1
    assign fin_vld = valid_in;
  end else begin : g_fvn
    assign fin_vld = vld_pipe[STAGES-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stg_t        cur;
    stg_t        nxt;
    logic [CW:0] csum;

    if (k == 0) begin : g_in
      always_comb begin
        cur     = '0;
        cur.a   = a;
        cur.b   = op ? ~b : b;
        cur.cy  = op;
        cur.sat = sat;
      end
    end else begin : g_mid
      assign cur = g_stg[k-1].g_reg.q;
    end

    assign csum = {1'b0, cur.a[k*CW +: CW]} + {1'b0, cur.b[k*CW +: CW]} + {{CW{1'b0}}, cur.cy};

    always_comb begin
      nxt                = cur;
      nxt.s[k*CW +: CW]  = csum[CW-1:0];
      nxt.cy             = csum[CW];
    end

    if (k < STAGES - 1) begin : g_reg
      stg_t q;
      always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (enb) q <= nxt;
      end
    end
  end

  stg_t             fin;
  logic             ovf_n;
  logic [WIDTH-1:0] c_n;

  assign fin = g_stg[STAGES-1].nxt;

  always_comb begin
    ovf_n = (fin.a[WIDTH-1] == fin.b[WIDTH-1]) && (fin.s[WIDTH-1] != fin.a[WIDTH-1]);
    c_n   = fin.s;
    if (fin.sat && ovf_n)
      c_n = fin.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Result registers only move on a valid op, so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      c     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (enb && fin_vld) begin
      c     <= c_n;
      carry <= fin.cy;
      ovf   <= ovf_n;
    end
  end

endmodule

// File: tb/tb_sumador_segmentado.sv
// Directed bench for sumador_segmentado: 8/2 main instance plus 16/1 and 16/4 for latency and reset.
module tb_sumador_segmentado;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst, enb, vi, op, sat;
  logic [7:0] a, b, c;
  logic       cy, ov, vo;

  logic        rst1, vi1, op1, sat1, cy1, ov1, vo1;
  logic [15:0] a1, b1, c1;
  logic        rst4, vi4, op4, sat4, cy4, ov4, vo4;
  logic [15:0] a4, b4, c4;

  sumador_segmentado #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .enb(enb), .valid_in(vi), .a(a), .b(b), .op(op), .sat(sat),
    .c(c), .carry(cy), .ovf(ov), .valid_out(vo));

  sumador_segmentado #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst1), .enb(enb), .valid_in(vi1), .a(a1), .b(b1), .op(op1), .sat(sat1),
    .c(c1), .carry(cy1), .ovf(ov1), .valid_out(vo1));

  sumador_segmentado #(.WIDTH(16), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst4), .enb(enb), .valid_in(vi4), .a(a4), .b(b4), .op(op4), .sat(sat4),
    .c(c4), .carry(cy4), .ovf(ov4), .valid_out(vo4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op on the 8/2 instance: result after 2 cycles, then a bubble.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic top, input logic tsat,
                      input logic [7:0] ec, input logic ecy, input logic eov);
    a = ta; b = tb_; op = top; sat = tsat; vi = 1'b1;
    tick();
    vi = 1'b0;
    chk({tag, "_vo_early"}, vo, 1'b0);
    tick();
    chk({tag, "_c"}, c, ec);
    chk({tag, "_carry"}, cy, ecy);
    chk({tag, "_ovf"}, ov, eov);
    chk({tag, "_vo"}, vo, 1'b1);
    tick();
    chk({tag, "_vo_once"}, vo, 1'b0);
    chk({tag, "_c_hold"}, c, ec);
  endtask

  logic [7:0] sa [4];
  logic [7:0] sc [4];

  initial begin
    rst = 1'b1; rst1 = 1'b1; rst4 = 1'b1; enb = 1'b1;
    vi = 1'b0; vi1 = 1'b0; vi4 = 1'b0;
    a = '0; b = '0; op = 1'b0; sat = 1'b0;
    a1 = '0; b1 = '0; op1 = 1'b0; sat1 = 1'b0;
    a4 = '0; b4 = '0; op4 = 1'b0; sat4 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
    chk("rst_c", c, 8'h00);
    chk("rst_carry", cy, 1'b0);
    chk("rst_ovf", ov, 1'b0);
    chk("rst_vo", vo, 1'b0);

    run8("add",      8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    run8("ovf_wrap", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("ovf_sat",  8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    run8("sub_sat",  8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    run8("borrow",   8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    run8("xchunk",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // Streaming: four back-to-back ops, results on consecutive cycles
    sa[0] = 8'h01; sa[1] = 8'h02; sa[2] = 8'h03; sa[3] = 8'hFF;
    sc[0] = 8'h02; sc[1] = 8'h04; sc[2] = 8'h06; sc[3] = 8'h00;
    op = 1'b0; sat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        a = sa[i]; b = (i == 3) ? 8'h01 : sa[i]; vi = 1'b1;
      end else begin
        vi = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("stream%0d_c", i - 1), c, sc[i-1]);
        chk($sformatf("stream%0d_vo", i - 1), vo, 1'b1);
        chk($sformatf("stream%0d_carry", i - 1), cy, (i == 4) ? 1'b1 : 1'b0);
      end
    end
    tick();
    chk("stream_end_vo", vo, 1'b0);

    // Stall with an op in flight; valid_in asserted during the stall must be ignored
    a = 8'h05; b = 8'h06; vi = 1'b1;
    tick();
    enb = 1'b0; a = 8'h55; b = 8'h55; vi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_c", i), c, 8'h00);
      chk($sformatf("stall%0d_vo", i), vo, 1'b0);
    end
    vi = 1'b0; enb = 1'b1;
    tick();
    chk("resume_c", c, 8'h0B);
    chk("resume_vo", vo, 1'b1);
    tick();
    chk("bubble_vo", vo, 1'b0);
    chk("bubble_c", c, 8'h0B);

    // Stall while valid_out is high holds it high
    a = 8'h01; b = 8'h02; vi = 1'b1;
    tick();
    vi = 1'b0;
    tick();
    chk("vhold_pre", vo, 1'b1);
    enb = 1'b0;
    tick();
    chk("vhold_vo", vo, 1'b1);
    chk("vhold_c", c, 8'h03);
    enb = 1'b1;
    tick();
    chk("vhold_post", vo, 1'b0);

    // Reset mid-flight discards the op
    a = 8'h20; b = 8'h20; vi = 1'b1;
    tick();
    vi = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_c", c, 8'h00);
    chk("rstmid_vo", vo, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid%0d_vo", i), vo, 1'b0);
      chk($sformatf("rstmid%0d_c", i), c, 8'h00);
    end

    // Reset coincident with valid_in: reset wins
    a = 8'h20; b = 8'h20; vi = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; vi = 1'b0;
    tick(); tick();
    chk("rstsim_vo", vo, 1'b0);
    chk("rstsim_c", c, 8'h00);

    // STAGES=1, WIDTH=16: latency 1
    a1 = 16'h1234; b1 = 16'h1111; vi1 = 1'b1;
    tick();
    vi1 = 1'b0;
    chk("s1_add_c", c1, 16'h2345);
    chk("s1_add_vo", vo1, 1'b1);
    tick();
    chk("s1_add_vo_once", vo1, 1'b0);
    a1 = 16'h0000; b1 = 16'h0001; op1 = 1'b1; vi1 = 1'b1;
    tick();
    vi1 = 1'b0; op1 = 1'b0;
    chk("s1_sub_c", c1, 16'hFFFF);
    chk("s1_sub_carry", cy1, 1'b0);
    a1 = 16'h2020; b1 = 16'h2020; vi1 = 1'b1; rst1 = 1'b1;
    tick();
    rst1 = 1'b0; vi1 = 1'b0;
    chk("s1_rst_c", c1, 16'h0000);
    chk("s1_rst_vo", vo1, 1'b0);
    tick();
    chk("s1_rst_c2", c1, 16'h0000);

    // STAGES=4, WIDTH=16: latency 4, carry rippling through every chunk
    a4 = 16'h0FFF; b4 = 16'h0001; vi4 = 1'b1;
    tick();
    vi4 = 1'b0;
    tick(); tick();
    chk("s4_vo_early", vo4, 1'b0);
    tick();
    chk("s4_c", c4, 16'h1000);
    chk("s4_vo", vo4, 1'b1);
    chk("s4_carry", cy4, 1'b0);
    tick();
    chk("s4_vo_once", vo4, 1'b0);
    a4 = 16'h2020; b4 = 16'h2020; vi4 = 1'b1;
    tick();
    vi4 = 1'b0; rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s4_rst%0d_vo", i), vo4, 1'b0);
      chk($sformatf("s4_rst%0d_c", i), c4, 16'h0000);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
